// File: rtl/mcu_spi_select_if.sv
`default_nettype none
// ============================================================================
// Module      : mcu_spi_select_if
// Description : Three-wire MCU->FPGA SPI bundle (clock, chip select, data).
// Revision    : 1.0 - initial release
// ============================================================================
interface mcu_spi_select_if;
  logic sclk;
  logic csn;
  logic mosi;

  modport master (output sclk, output csn, output mosi);
  modport slave  (input  sclk, input  csn, input  mosi);
endinterface
`default_nettype wire

// File: rtl/mcu_spi_select.sv
`default_nettype none
// ============================================================================
// Module      : mcu_spi_select
// Description : Chooses the internal BL616 or an external M0S Dock as the SPI
//               master of the core, switching once at a clean boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module mcu_spi_select #(
  parameter int SYNC_STAGES   = 2,
  parameter int DETECT_CYCLES = 8,
  parameter int GUARD_CYCLES  = 2
) (
  input  wire                    clk32,
  input  wire                    por,
  mcu_spi_select_if.slave        int_spi,
  mcu_spi_select_if.slave        ext_spi,
  mcu_spi_select_if.master       mcu_spi,
  output logic                   spi_ext,
  output logic                   switch_pulse
);

  localparam int c_DET_W = $clog2(DETECT_CYCLES + 1);
  localparam int c_GRD_W = $clog2(GUARD_CYCLES + 1);

  localparam logic [c_DET_W-1:0] c_DET_ONE  = c_DET_W'(1);
  localparam logic [c_DET_W-1:0] c_DET_LAST = c_DET_W'(DETECT_CYCLES - 1);
  localparam logic [c_GRD_W-1:0] c_GRD_ONE  = c_GRD_W'(1);
  localparam logic [c_GRD_W-1:0] c_GRD_LAST = c_GRD_W'(GUARD_CYCLES);

  // Bit order: {int_sclk, int_csn, int_mosi, ext_sclk, ext_csn, ext_mosi}
  localparam logic [5:0] c_SYNC_PRESET = 6'b010_010;

  typedef enum logic [2:0] {
    S_INT   = 3'd0,
    S_ARM   = 3'd1,
    S_DRAIN = 3'd2,
    S_GUARD = 3'd3,
    S_EXT   = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0][5:0] r_sync;
  logic [5:0]                  w_sync_out;
  logic                        w_int_sclk_s, w_int_csn_s, w_int_mosi_s;
  logic                        w_ext_sclk_s, w_ext_csn_s, w_ext_mosi_s;

  state_t                      r_state, w_state_next;
  logic [c_DET_W-1:0]          r_det_cnt, w_det_next;
  logic [c_GRD_W-1:0]          r_grd_cnt, w_grd_next;

  logic                        w_sclk_d, w_csn_d, w_mosi_d;
  logic                        r_mcu_sclk, r_mcu_csn, r_mcu_mosi;
  logic                        r_spi_ext, r_switch_pulse;

  always_ff @(posedge clk32 or posedge por) begin
    if (por) begin
      r_sync <= {SYNC_STAGES{c_SYNC_PRESET}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0],
                 {int_spi.sclk, int_spi.csn, int_spi.mosi,
                  ext_spi.sclk, ext_spi.csn, ext_spi.mosi}};
    end
  end

  assign w_sync_out   = r_sync[SYNC_STAGES-1];
  assign w_int_sclk_s = w_sync_out[5];
  assign w_int_csn_s  = w_sync_out[4];
  assign w_int_mosi_s = w_sync_out[3];
  assign w_ext_sclk_s = w_sync_out[2];
  assign w_ext_csn_s  = w_sync_out[1];
  assign w_ext_mosi_s = w_sync_out[0];

  always_ff @(posedge clk32 or posedge por) begin
    if (por) begin
      r_state   <= S_INT;
      r_det_cnt <= '0;
      r_grd_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_det_cnt <= w_det_next;
      r_grd_cnt <= w_grd_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_det_next   = r_det_cnt;
    w_grd_next   = r_grd_cnt;
    w_sclk_d     = w_int_sclk_s;
    w_csn_d      = w_int_csn_s;
    w_mosi_d     = w_int_mosi_s;

    case (r_state)
      S_INT: begin
        if (!w_ext_csn_s) begin
          w_state_next = S_ARM;
          w_det_next   = c_DET_ONE;
        end
      end
      S_ARM: begin
        if (w_ext_csn_s) begin
          w_state_next = S_INT;
          w_det_next   = '0;
        end else if (r_det_cnt >= c_DET_LAST) begin
          w_state_next = S_DRAIN;
        end else begin
          w_det_next   = r_det_cnt + c_DET_ONE;
        end
      end
      // Once committed, only the internal transaction end matters.
      S_DRAIN: begin
        if (w_int_csn_s) begin
          w_state_next = S_GUARD;
          w_grd_next   = c_GRD_ONE;
        end
      end
      S_GUARD: begin
        w_sclk_d = 1'b0;
        w_csn_d  = 1'b1;
        w_mosi_d = 1'b0;
        if (r_grd_cnt == c_GRD_LAST) begin
          w_state_next = S_EXT;
        end else begin
          w_grd_next   = r_grd_cnt + c_GRD_ONE;
        end
      end
      S_EXT: begin
        w_sclk_d = w_ext_sclk_s;
        w_csn_d  = w_ext_csn_s;
        w_mosi_d = w_ext_mosi_s;
      end
      default: begin
        w_state_next = S_INT;
      end
    endcase
  end

  always_ff @(posedge clk32 or posedge por) begin
    if (por) begin
      r_mcu_sclk     <= 1'b0;
      r_mcu_csn      <= 1'b1;
      r_mcu_mosi     <= 1'b0;
      r_spi_ext      <= 1'b0;
      r_switch_pulse <= 1'b0;
    end else begin
      r_mcu_sclk     <= w_sclk_d;
      r_mcu_csn      <= w_csn_d;
      r_mcu_mosi     <= w_mosi_d;
      r_spi_ext      <= (w_state_next == S_EXT);
      r_switch_pulse <= (w_state_next == S_EXT) && (r_state != S_EXT);
    end
  end

  assign mcu_spi.sclk  = r_mcu_sclk;
  assign mcu_spi.csn   = r_mcu_csn;
  assign mcu_spi.mosi  = r_mcu_mosi;
  assign spi_ext       = r_spi_ext;
  assign switch_pulse  = r_switch_pulse;

endmodule
`default_nettype wire

// File: tb/tb_mcu_spi_select.sv
`default_nettype none
// ============================================================================
// Module      : tb_mcu_spi_select
// Description : Randomised bench for mcu_spi_select against an event-time model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mcu_spi_select;

  localparam int         SYNC    = 2;
  localparam int         DET     = 8;
  localparam int         GRD     = 2;
  localparam int         DET_EFF = (DET < 2) ? 2 : DET;
  localparam logic [5:0] PRESET  = 6'b010_010;

  logic clk32 = 1'b0;
  logic por   = 1'b1;
  logic spi_ext;
  logic switch_pulse;

  mcu_spi_select_if int_bus ();
  mcu_spi_select_if ext_bus ();
  mcu_spi_select_if mcu_bus ();

  mcu_spi_select #(
    .SYNC_STAGES   (SYNC),
    .DETECT_CYCLES (DET),
    .GUARD_CYCLES  (GRD)
  ) u_dut (
    .clk32        (clk32),
    .por          (por),
    .int_spi      (int_bus),
    .ext_spi      (ext_bus),
    .mcu_spi      (mcu_bus),
    .spi_ext      (spi_ext),
    .switch_pulse (switch_pulse)
  );

  always #16 clk32 = ~clk32;

  int total = 0;
  int bad   = 0;

  // Model: pin history per edge plus the edge numbers of each switch event.
  logic [5:0] hist[$];
  int k, run, t_drain, t_guard, t_ext;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask

  function automatic logic [5:0] pins_now();
    return {int_bus.sclk, int_bus.csn, int_bus.mosi, ext_bus.sclk, ext_bus.csn, ext_bus.mosi};
  endfunction

  function automatic logic [5:0] synced(input int kk);
    if (kk - SYNC < 1) return PRESET;
    return hist[kk - SYNC - 1];
  endfunction

  task automatic model_reset();
    hist.delete();
    k = 0; run = 0; t_drain = -1; t_guard = -1; t_ext = -1;
  endtask

  task automatic step();
    logic [5:0] s;
    logic [2:0] exp_o;
    logic       in_ext, in_grd;
    @(posedge clk32);
    k++;
    hist.push_back(pins_now());
    s      = synced(k);
    in_ext = (t_ext >= 0) && (k > t_ext);
    in_grd = (t_guard >= 0) && (k > t_guard) && !in_ext;
    if (in_grd)      exp_o = 3'b010;
    else if (in_ext) exp_o = s[2:0];
    else             exp_o = s[5:3];
    if (t_drain < 0) begin
      if (!s[1]) run++; else run = 0;
      if (run >= DET_EFF) t_drain = k;
    end else if (t_guard < 0 && k > t_drain && s[4]) begin
      t_guard = k;
      t_ext   = k + GRD;
    end
    #1;
    check_val("mcu_sclk", mcu_bus.sclk, exp_o[2]);
    check_val("mcu_csn", mcu_bus.csn, exp_o[1]);
    check_val("mcu_mosi", mcu_bus.mosi, exp_o[0]);
    check_val("spi_ext", spi_ext, (t_ext >= 0) && (k >= t_ext));
    check_val("switch_pulse", switch_pulse, (k == t_ext));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_sclk"}, mcu_bus.sclk, 1'b0);
    check_val({tag, "_csn"}, mcu_bus.csn, 1'b1);
    check_val({tag, "_mosi"}, mcu_bus.mosi, 1'b0);
    check_val({tag, "_spi_ext"}, spi_ext, 1'b0);
    check_val({tag, "_pulse"}, switch_pulse, 1'b0);
  endtask

  task automatic rand_int_traffic();
    int_bus.sclk = 1'($urandom_range(0, 1));
    int_bus.mosi = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 3) == 0) int_bus.csn = ~int_bus.csn;
  endtask

  task automatic rand_ext_data();
    ext_bus.sclk = 1'($urandom_range(0, 1));
    ext_bus.mosi = 1'($urandom_range(0, 1));
  endtask

  task automatic int_idle();
    int_bus.sclk = 1'b0; int_bus.csn = 1'b1; int_bus.mosi = 1'b0;
  endtask

  // Called just after a posedge; asserts por with random pins, then releases.
  task automatic do_reset(input string tag);
    por = 1'b1;
    rand_int_traffic();
    rand_ext_data();
    ext_bus.csn = 1'($urandom_range(0, 1));
    #2;
    check_reset_outputs(tag);
    repeat (2) @(posedge clk32);
    #1;
    por = 1'b0;
    model_reset();
  endtask

  initial begin
    int obs_edge, pulses;
    bit found;
    int_idle();
    ext_bus.sclk = 1'b0; ext_bus.csn = 1'b1; ext_bus.mosi = 1'b0;
    model_reset();
    @(posedge clk32);
    #1;

    // Reset, then internal traffic with the external MCU idle.
    do_reset("rst");
    ext_bus.csn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      rand_int_traffic(); rand_ext_data();
      step();
    end

    // Short external chip-select glitches must be rejected.
    for (int g = 0; g < 6; g++) begin
      int lo, hi;
      lo = $urandom_range(1, DET_EFF - 1);
      hi = $urandom_range(3, 6);
      ext_bus.csn = 1'b0;
      for (int i = 0; i < lo; i++) begin rand_int_traffic(); rand_ext_data(); step(); end
      ext_bus.csn = 1'b1;
      for (int i = 0; i < hi; i++) begin rand_int_traffic(); rand_ext_data(); step(); end
    end
    check_val("glitch_no_switch", spi_ext, 1'b0);

    // Internal burst in progress while the external MCU claims the bus.
    int_bus.csn = 1'b0; ext_bus.csn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      int_bus.sclk = ~int_bus.sclk;
      int_bus.mosi = 1'($urandom_range(0, 1));
      rand_ext_data();
      step();
    end
    check_val("drain_holds", spi_ext, 1'b0);
    int_idle();
    for (int i = 0; i < 10; i++) begin rand_ext_data(); step(); end
    check_val("ext_selected", spi_ext, 1'b1);
    for (int i = 0; i < 40; i++) begin
      rand_int_traffic(); rand_ext_data();
      if ($urandom_range(0, 2) == 0) ext_bus.csn = ~ext_bus.csn;
      step();
    end

    // Directed switch-over timing with default parameters.
    do_reset("rst2");
    int_idle();
    ext_bus.csn = 1'b0;
    obs_edge = -1; pulses = 0;
    for (int i = 0; i < 30; i++) begin
      rand_ext_data();
      step();
      if (spi_ext === 1'b1 && obs_edge < 0) obs_edge = k;
      if (switch_pulse === 1'b1) pulses++;
    end
    check_val("switch_edge", obs_edge, 13);
    check_val("pulse_count", pulses, 1);

    // Reset asserted while the outputs are forced idle.
    do_reset("rst3");
    int_idle();
    ext_bus.csn = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      rand_ext_data();
      step();
      if (t_guard >= 0 && k >= t_guard && k < t_ext) found = 1'b1;
    end
    check_val("reach_guard", found, 1'b1);
    #2;
    por = 1'b1;
    ext_bus.csn = 1'b1;
    #1;
    check_reset_outputs("por_guard");
    repeat (2) @(posedge clk32);
    #1;
    por = 1'b0;
    model_reset();
    for (int i = 0; i < 30; i++) begin rand_int_traffic(); rand_ext_data(); step(); end
    check_val("stay_int", spi_ext, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
